// File: rtl/aq_vidu_vid_wbt_wb_ctrl_pkg.sv
// Shared VIDU WBT configuration: table geometry, deferred-buffer depth and
// the write-back request record passed between the pipes and the collector.
package aq_vidu_vid_wbt_wb_ctrl_pkg;

    localparam int ENTRY_NUM = 32;
    localparam int IDX_W     = 5;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } wb_req_t;

    // Two live requests aimed at the same WBT entry collide.
    function automatic logic req_hit(input wb_req_t a, input wb_req_t b);
        return a.vld && b.vld && (a.idx == b.idx);
    endfunction

endpackage

// File: rtl/aq_vidu_vid_wbt_wb_buf.sv
// Deferred write-back FIFO: two ordered write ports, one head read port,
// wrap-bit pointers and a synchronous clear.
module aq_vidu_vid_wbt_wb_buf
    import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
(
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             buf_clr,
    input  logic             wr0_en,
    input  logic [IDX_W-1:0] wr0_idx,
    input  logic             wr1_en,
    input  logic [IDX_W-1:0] wr1_idx,
    input  logic             rd_en,
    output logic             head_vld,
    output logic [IDX_W-1:0] head_idx,
    output logic [CNT_W-1:0] buf_cnt,
    output logic [CNT_W-1:0] buf_cnt_nxt
);
    localparam int ADDR_W = $clog2(BUF_DEPTH);

    logic [IDX_W-1:0] mem [BUF_DEPTH];
    logic [CNT_W-1:0] wptr_reg, rptr_reg, wptr_nxt, rptr_nxt;
    logic [CNT_W-1:0] space, wr1_ptr;
    logic             rd_ok, wr0_ok, wr1_ok, overflow;

    always_comb begin
        buf_cnt  = wptr_reg - rptr_reg;
        head_vld = (wptr_reg != rptr_reg);
        head_idx = mem[rptr_reg[ADDR_W-1:0]];
        rd_ok    = rd_en && head_vld;
        // Free slots this cycle include the one vacated by the dequeue.
        space    = CNT_W'(BUF_DEPTH) - buf_cnt + CNT_W'(rd_ok);
        wr0_ok   = wr0_en && (space != '0);
        wr1_ok   = wr1_en && (space > CNT_W'(wr0_ok));
        wr1_ptr  = wptr_reg + CNT_W'(wr0_ok);
        overflow = (wr0_en && !wr0_ok) || (wr1_en && !wr1_ok);
        if (buf_clr) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            wptr_nxt = wptr_reg + CNT_W'(wr0_ok) + CNT_W'(wr1_ok);
            rptr_nxt = rptr_reg + CNT_W'(rd_ok);
        end
        buf_cnt_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_nxt;
            rptr_reg <= rptr_nxt;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!buf_clr) begin
            if (wr0_ok) mem[wptr_reg[ADDR_W-1:0]] <= wr0_idx;
            if (wr1_ok) mem[wr1_ptr[ADDR_W-1:0]]  <= wr1_idx;
        end
    end

    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(overflow && !buf_clr));

endmodule

// File: rtl/aq_vidu_vid_wbt_wb_ctrl.sv
// Write-back collector: arbitrates FIFO head, VEX and LSU reports into a
// registered one-hot-per-entry enable, deferring same-cycle collisions.
module aq_vidu_vid_wbt_wb_ctrl
    import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 vex_vidu_wb_vld,
    input  logic [IDX_W-1:0]     vex_vidu_wb_dstv_idx,
    input  logic                 lsu_vidu_wb_vld,
    input  logic [IDX_W-1:0]     lsu_vidu_wb_dstv_idx,
    input  logic                 rtu_vidu_flush_wbt,
    input  logic                 rtu_yy_xx_async_flush,
    output logic [ENTRY_NUM-1:0] wbt_wb_en,
    output logic                 wbt_wb_clk_en,
    output logic                 wbt_wb_stall_create,
    output logic [CNT_W-1:0]     wbt_wb_buf_cnt
);
    logic                 flush;
    logic                 head_vld;
    logic [IDX_W-1:0]     head_idx;
    logic [CNT_W-1:0]     buf_cnt_nxt;
    wb_req_t              head_req, vex_req, lsu_req, vex_gnt_req;
    logic                 vex_gnt, lsu_gnt, vex_defer, lsu_defer;
    logic [ENTRY_NUM-1:0] wb_en_nxt;
    logic [ENTRY_NUM-1:0] wb_en_reg;
    logic                 stall_reg;

    assign flush = rtu_vidu_flush_wbt | rtu_yy_xx_async_flush;

    // The head always wins, so a non-empty buffer drains one entry per cycle.
    always_comb begin
        head_req    = '{vld: head_vld, idx: head_idx};
        vex_req     = '{vld: vex_vidu_wb_vld, idx: vex_vidu_wb_dstv_idx};
        lsu_req     = '{vld: lsu_vidu_wb_vld, idx: lsu_vidu_wb_dstv_idx};
        vex_gnt     = vex_req.vld && !req_hit(vex_req, head_req);
        vex_gnt_req = '{vld: vex_gnt, idx: vex_vidu_wb_dstv_idx};
        lsu_gnt     = lsu_req.vld && !req_hit(lsu_req, head_req)
                                  && !req_hit(lsu_req, vex_gnt_req);
        vex_defer   = vex_req.vld && !vex_gnt;
        lsu_defer   = lsu_req.vld && !lsu_gnt;
    end

    aq_vidu_vid_wbt_wb_buf u_wb_buf (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .buf_clr        (flush),
        .wr0_en         (vex_defer & ~flush),
        .wr0_idx        (vex_vidu_wb_dstv_idx),
        .wr1_en         (lsu_defer & ~flush),
        .wr1_idx        (lsu_vidu_wb_dstv_idx),
        .rd_en          (head_vld & ~flush),
        .head_vld       (head_vld),
        .head_idx       (head_idx),
        .buf_cnt        (wbt_wb_buf_cnt),
        .buf_cnt_nxt    (buf_cnt_nxt)
    );

    // Indices beyond the table simply match no entry and are dropped.
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_dec
        assign wb_en_nxt[gi] = ~flush &
            ((head_vld & (head_idx == IDX_W'(gi))) |
             (vex_gnt  & (vex_vidu_wb_dstv_idx == IDX_W'(gi))) |
             (lsu_gnt  & (lsu_vidu_wb_dstv_idx == IDX_W'(gi))));
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wb_en_reg <= '0;
            stall_reg <= 1'b0;
        end else begin
            wb_en_reg <= wb_en_nxt;
            stall_reg <= (buf_cnt_nxt > CNT_W'(BUF_DEPTH - 2));
        end
    end

    assign wbt_wb_en           = wb_en_reg;
    assign wbt_wb_stall_create = stall_reg;
    assign wbt_wb_clk_en       = ((|wb_en_nxt) | flush) & ~cpurst;

endmodule

// File: tb/tb_aq_vidu_vid_wbt_wb_ctrl.sv
// Randomized bench for the WBT write-back collector against a queue-based model.
module tb_aq_vidu_vid_wbt_wb_ctrl;
    logic        forever_cpuclk = 1'b0;
    logic        cpurst = 1'b1;
    logic        vex_vidu_wb_vld = 1'b0;
    logic [4:0]  vex_vidu_wb_dstv_idx = '0;
    logic        lsu_vidu_wb_vld = 1'b0;
    logic [4:0]  lsu_vidu_wb_dstv_idx = '0;
    logic        rtu_vidu_flush_wbt = 1'b0;
    logic        rtu_yy_xx_async_flush = 1'b0;
    logic [31:0] wbt_wb_en;
    logic        wbt_wb_clk_en;
    logic        wbt_wb_stall_create;
    logic [2:0]  wbt_wb_buf_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int model_q[$];

    aq_vidu_vid_wbt_wb_ctrl dut (
        .forever_cpuclk        (forever_cpuclk),
        .cpurst                (cpurst),
        .vex_vidu_wb_vld       (vex_vidu_wb_vld),
        .vex_vidu_wb_dstv_idx  (vex_vidu_wb_dstv_idx),
        .lsu_vidu_wb_vld       (lsu_vidu_wb_vld),
        .lsu_vidu_wb_dstv_idx  (lsu_vidu_wb_dstv_idx),
        .rtu_vidu_flush_wbt    (rtu_vidu_flush_wbt),
        .rtu_yy_xx_async_flush (rtu_yy_xx_async_flush),
        .wbt_wb_en             (wbt_wb_en),
        .wbt_wb_clk_en         (wbt_wb_clk_en),
        .wbt_wb_stall_create   (wbt_wb_stall_create),
        .wbt_wb_buf_cnt        (wbt_wb_buf_cnt)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: present inputs, predict, check clk_en mid-cycle and state after the edge.
    task automatic step(input logic vv, input int vi, input logic lv, input int li,
                        input logic fl, input logic af);
        logic [31:0] en;
        int          h;
        vex_vidu_wb_vld       = vv;
        vex_vidu_wb_dstv_idx  = 5'(vi);
        lsu_vidu_wb_vld       = lv;
        lsu_vidu_wb_dstv_idx  = 5'(li);
        rtu_vidu_flush_wbt    = fl;
        rtu_yy_xx_async_flush = af;
        en = '0;
        if (fl || af) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0) begin
                h = model_q.pop_front();
                en[h] = 1'b1;
            end
            if (vv) begin
                if (en[vi]) model_q.push_back(vi);
                else        en[vi] = 1'b1;
            end
            if (lv) begin
                if (en[li]) model_q.push_back(li);
                else        en[li] = 1'b1;
            end
        end
        #3;
        chk("clk_en", {31'b0, wbt_wb_clk_en}, {31'b0, (en != 0) || fl || af});
        @(posedge forever_cpuclk);
        #1;
        chk("wb_en", wbt_wb_en, en);
        chk("buf_cnt", 32'(wbt_wb_buf_cnt), 32'(model_q.size()));
        chk("stall", {31'b0, wbt_wb_stall_create}, 32'(model_q.size() > 2));
        $display("vex=%0d/%0d lsu=%0d/%0d fl=%0d/%0d -> wb_en=%08h cnt=%0d stall=%0d",
                 vv, vi, lv, li, fl, af, wbt_wb_en, wbt_wb_buf_cnt, wbt_wb_stall_create);
    endtask

    initial begin
        #12;
        chk("rst_wb_en", wbt_wb_en, 32'h0);
        chk("rst_cnt", 32'(wbt_wb_buf_cnt), 32'h0);
        chk("rst_stall", {31'b0, wbt_wb_stall_create}, 32'h0);
        chk("rst_clk_en", {31'b0, wbt_wb_clk_en}, 32'h0);
        cpurst = 1'b0;
        @(posedge forever_cpuclk);
        #1;

        step(1, 5, 0, 0, 0, 0);
        chk("single_bit5", wbt_wb_en, 32'h0000_0020);
        step(0, 0, 0, 0, 0, 0);
        step(1, 3, 1, 9, 0, 0);
        chk("pair_3_9", wbt_wb_en, 32'h0000_0208);
        step(1, 7, 1, 7, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 7, 1, 7, 0, 0);
        step(1, 7, 1, 2, 0, 0);
        chk("head_prio", wbt_wb_en, 32'h0000_0084);
        step(0, 0, 0, 0, 0, 0);
        step(1, 7, 1, 7, 0, 0);
        step(1, 7, 1, 7, 0, 0);
        step(1, 7, 1, 7, 0, 0);
        chk("stall_full", {31'b0, wbt_wb_stall_create}, 32'h1);
        step(1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset mid-operation with two deferred entries pending.
        step(1, 7, 1, 7, 0, 0);
        step(1, 7, 1, 7, 0, 0);
        vex_vidu_wb_vld = 1'b0;
        lsu_vidu_wb_vld = 1'b0;
        cpurst = 1'b1;
        #2;
        model_q.delete();
        chk("mid_rst_wb_en", wbt_wb_en, 32'h0);
        chk("mid_rst_cnt", 32'(wbt_wb_buf_cnt), 32'h0);
        chk("mid_rst_stall", {31'b0, wbt_wb_stall_create}, 32'h0);
        chk("mid_rst_clk_en", {31'b0, wbt_wb_clk_en}, 32'h0);
        cpurst = 1'b0;
        @(posedge forever_cpuclk);
        #1;
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic vv, lv, fl, af;
            int   vi, li;
            vv = (model_q.size() <= 2) && ($urandom_range(0, 3) != 0);
            lv = (model_q.size() <= 2) && ($urandom_range(0, 3) != 0);
            vi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
            li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
            fl = ($urandom_range(0, 19) == 0);
            af = ($urandom_range(0, 39) == 0);
            step(vv, vi, lv, li, fl, af);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
